// File: rtl/slc3_io_pkg.sv
// Shared constants and segment lookup for the memory/I-O bridge.
// Segment encoding is {g,f,e,d,c,b,a}, active-low.
package slc3_io_pkg;

  localparam logic [15:0] IO_ADDR_DEFAULT = 16'hFFFF;
  localparam logic [6:0]  SEG_OFF         = 7'h7F;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mem_io_bridge_hex7seg.sv
// Combinational hex nibble to 7-segment decoder.
// Output is active-low {g,f,e,d,c,b,a}.
module hex7seg
  import slc3_io_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  assign o_seg = hex_to_seg(i_nib);

endmodule

// File: rtl/mem_io_bridge.sv
// SRAM strobe gating, memory-mapped switch/hex I/O port,
// and a multiplexed 4-digit 7-segment scanner.
module mem_io_bridge
  import slc3_io_pkg::*;
#(
  parameter logic [15:0] IO_ADDR   = IO_ADDR_DEFAULT,
  parameter int          SCAN_BITS = 16
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] ADDR,
  input  logic        Mem_CE,
  input  logic        Mem_OE,
  input  logic        Mem_WE,
  input  logic [15:0] Data_from_CPU,
  input  logic [15:0] Data_from_SRAM,
  input  logic [15:0] Switches,
  output logic [15:0] Data_to_CPU,
  output logic [15:0] Data_to_SRAM,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_WE_N,
  output logic [15:0] HEX_reg,
  output logic [6:0]  HEX_SEG,
  output logic [3:0]  HEX_AN
);

  logic                 w_io_sel;
  logic                 w_wr;
  logic                 w_rd;
  logic                 w_wr_io;
  logic [15:0]          r_sw_meta;
  logic [15:0]          r_sw_sync;
  logic                 r_wr_q;
  logic [15:0]          r_hex_reg;
  logic [SCAN_BITS-1:0] r_cnt;
  logic [1:0]           w_d;
  logic [3:0]           w_bitpos;
  logic [3:0]           w_nib;
  logic [6:0]           w_seg;
  logic [3:0]           r_an;
  logic [6:0]           r_seg;

  assign w_io_sel = (ADDR == IO_ADDR);
  assign w_wr     = ~Mem_CE & ~Mem_WE;
  assign w_rd     = ~Mem_CE & ~Mem_OE & Mem_WE;
  assign w_wr_io  = w_wr & w_io_sel;

  assign SRAM_CE_N    = Mem_CE;
  assign SRAM_OE_N    = Mem_OE | w_io_sel | w_wr;
  assign SRAM_WE_N    = Mem_WE | w_io_sel;
  assign Data_to_SRAM = w_wr ? Data_from_CPU : 16'h0000;

  always_comb begin
    Data_to_CPU = 16'h0000;
    unique case (1'b1)
      (w_rd & w_io_sel):  Data_to_CPU = r_sw_sync;
      (w_rd & ~w_io_sel): Data_to_CPU = Data_from_SRAM;
      default: ;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_sw_meta <= '0;
      r_sw_sync <= '0;
    end else begin
      r_sw_meta <= Switches;
      r_sw_sync <= r_sw_meta;
    end
  end

  // Load only on the first cycle of a write burst.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_wr_q    <= 1'b0;
      r_hex_reg <= '0;
    end else begin
      r_wr_q <= w_wr_io;
      if (w_wr_io & ~r_wr_q)
        r_hex_reg <= Data_from_CPU;
    end
  end

  assign HEX_reg = r_hex_reg;

  assign w_d      = r_cnt[SCAN_BITS-1:SCAN_BITS-2];
  assign w_bitpos = {w_d, 2'b00};
  assign w_nib    = r_hex_reg[w_bitpos +: 4];

  hex7seg u_hex7seg (
    .i_nib (w_nib),
    .o_seg (w_seg)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_cnt <= '0;
      r_an  <= 4'hF;
      r_seg <= SEG_OFF;
    end else begin
      r_cnt <= r_cnt + 1'b1;
      r_an  <= ~(4'b0001 << w_d);
      r_seg <= w_seg;
    end
  end

  assign HEX_AN  = r_an;
  assign HEX_SEG = r_seg;

endmodule
